// File: rtl/fft_pkg.sv
// Shared FFT definitions: default address width, sequencer states,
// and the bit-reverse helper used by the read-address generator.
package fft_pkg;

  localparam int FFT_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } bitrev_state_t;

  // Reverses the low w bits of v; bits at and above w are returned as 0.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/up_counter_sclr.sv
// Up counter with enable, synchronous clear (priority over enable)
// and asynchronous active-low reset.
module up_counter_sclr #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         sclr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sclr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bitrev_addr_gen.sv
// Bit-reversed read-address sequencer for the FFT sample buffer.
// Optional natural-order mode: BITREV_ADDR_GEN_NATURAL_EN.
module bitrev_addr_gen
  import fft_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              abort,
  input  logic              addr_ready,
`ifdef BITREV_ADDR_GEN_NATURAL_EN
  input  logic              natural,
`endif
  output logic              addr_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              busy,
  output logic              done
);

  bitrev_state_t state_q;
  bitrev_state_t state_d;

  logic [ADDR_W-1:0] cnt;
  logic              run;
  logic              accept;
  logic              hs;
  logic              cnt_last;
  logic [31:0]       rev_w;
  logic [ADDR_W-1:0] ord_addr;
  logic              unused_rev;

  assign run      = (state_q == RUN);
  assign accept   = (state_q == IDLE) & start & ~abort;
  assign hs       = run & addr_ready & ~abort;
  assign cnt_last = &cnt;

  up_counter_sclr #(
    .W(ADDR_W)
  ) u_cnt (
    .clk_i (clk),
    .rst_ni(clr_n),
    .en_i  (hs),
    .sclr_i(accept | abort),
    .cnt_o (cnt)
  );

  assign rev_w      = bitrev(32'(cnt), ADDR_W);
  assign unused_rev = ^rev_w[31:ADDR_W];

`ifdef BITREV_ADDR_GEN_NATURAL_EN
  logic nat_q;
  logic nat_d;

  always_comb begin
    nat_d = nat_q;
    if (abort)       nat_d = 1'b0;
    else if (accept) nat_d = natural;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) nat_q <= 1'b0;
    else        nat_q <= nat_d;
  end

  assign ord_addr = nat_q ? cnt : rev_w[ADDR_W-1:0];
`else
  assign ord_addr = rev_w[ADDR_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (addr_ready && cnt_last) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign addr_valid = run;
  assign addr       = run ? ord_addr : '0;
  assign last       = run & cnt_last;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule
